// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector for a one-bit stream.
// Matches a WIDTH-bit PATTERN (MSB received first). It provides a same-cycle
// Mealy strobe (y), a registered Moore strobe (y_reg) and a saturating match
// counter (count). OVERLAP selects whether a match's trailing bits may seed
// the next match.
module seq_detector #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a,
    input  logic             clear,
    output logic             y,
    output logic             y_reg,
    output logic [CNT_W-1:0] count
);

    localparam int                FILL_W    = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH - 1);

    // Accepted-bit history (newest in LSB) and how many of its bits are valid.
    logic [WIDTH-2:0]  hist;
    logic [FILL_W-1:0] fill;

    // Candidate window: the stored history with the current bit appended.
    logic [WIDTH-1:0]  window;
    logic              match;

    // The count stops at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The fill level stops once the history holds WIDTH-1 valid bits.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        return (v == FILL_FULL) ? v : v + 1'b1;
    endfunction

    assign window = {hist, a};
    // Reset masks the strobe so that a partial history cannot fire while it
    // is being discarded.
    assign match  = en && !reset && (fill == FILL_FULL) && (window == PATTERN);
    assign y      = match;

    // History shift and fill tracking. A non-overlapping match restarts the
    // fill from zero. The stale hist bits are never compared until refilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            if (match && !OVERLAP) begin
                fill <= '0;
            end else begin
                hist <= window[WIDTH-2:0];
                fill <= fill_inc(fill);
            end
        end
    end

    // Registered copy of the Mealy strobe, one cycle behind y.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_reg <= 1'b0;
        end else begin
            y_reg <= match;
        end
    end

    // Match counter. Clear wins over a coincident match and touches nothing else.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (match) begin
            count <= sat_inc(count);
        end
    end

endmodule
